// File: rtl/encoder_scan_n.sv
// ---------------------------------------------------------------------------
// encoder_scan_n
//
// Registered bit-scan encoder. It accepts a WIDTH-bit request vector over a
// valid/ready handshake. It then streams out the binary index of every set
// bit, one index per beat, on a valid/ready output.
//
// Parameters
//   WIDTH      request vector width (>= 2)
//   MSB_FIRST  0: lowest set bit first, 1: highest set bit first
//   IDX_W      derived index width, $clog2(WIDTH) (not overridable)
//
// Optional feature macro: ENCODER_ZERO_FLAG_EN
//   defined     an accepted all-zero vector produces one beat with
//               o = 0, o_last = 1 and o_zero = 1
//   undefined   an all-zero vector is consumed silently and the o_zero
//               port does not exist
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   request vector present on i
//   in_ready  out  vector can be accepted this cycle (IDLE, not in reset)
//   i         in   [WIDTH-1:0] request vector
//   o_valid   out  index beat present on o
//   o_ready   in   downstream accepts the beat
//   o         out  [IDX_W-1:0] index of the currently selected bit
//   o_last    out  final beat of the current vector
//   o_zero    out  beat reports an all-zero vector (macro builds only)
//   busy      out  scan in progress
// ---------------------------------------------------------------------------
module encoder_scan_n #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [IDX_W-1:0] o,
  output logic             o_last,
`ifdef ENCODER_ZERO_FLAG_EN
  output logic             o_zero,
`endif
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  // One-hot mask of the bit selected for the current beat.
  logic [WIDTH-1:0] sel_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             single_bit;

  // A bit is selected when it is set and no bit ahead of it in scan order is
  // set. The "ahead" mask is a per-position constant, so each select bit is
  // a single AND with a reduction OR.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
      localparam logic [WIDTH-1:0] BIT_M   = WIDTH'(1) << gi;
      localparam logic [WIDTH-1:0] LOWER_M = BIT_M - WIDTH'(1);
      localparam logic [WIDTH-1:0] UPPER_M = ~(LOWER_M | BIT_M);
      if (MSB_FIRST) begin : g_msb
        assign sel_mask[gi] = pending_q[gi] & !(|(pending_q & UPPER_M));
      end else begin : g_lsb
        assign sel_mask[gi] = pending_q[gi] & !(|(pending_q & LOWER_M));
      end
    end
  endgenerate

  // One-hot to binary. Only legal indices (< WIDTH) can appear, so o stays
  // within range for non-power-of-two widths.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (sel_mask[k]) begin
        sel_idx = sel_idx | IDX_W'(k);
      end
    end
  end

  // At most one bit set. This is also true for an empty pending register,
  // which is exactly the zero-flag beat case.
  assign single_bit = ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_ready  = 1'b0;
    o_valid   = 1'b0;
    o         = '0;
    o_last    = 1'b0;
    busy      = 1'b0;
`ifdef ENCODER_ZERO_FLAG_EN
    o_zero    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Forced low during reset so upstream never sees a phantom accept.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          if (i != '0) begin
            pending_d = i;
            state_d   = SCAN;
          end else begin
`ifdef ENCODER_ZERO_FLAG_EN
            pending_d = '0;
            state_d   = SCAN;
`endif
          end
        end
      end
      SCAN: begin
        o_valid = 1'b1;
        busy    = 1'b1;
        o       = sel_idx;
        o_last  = single_bit;
`ifdef ENCODER_ZERO_FLAG_EN
        o_zero  = (pending_q == '0);
`endif
        if (o_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (single_bit) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_encoder_scan_n.sv
// ---------------------------------------------------------------------------
// tb_encoder_scan_n
//
// Directed bench for encoder_scan_n. Four instances share clock and reset:
//   d0: WIDTH=8,  MSB_FIRST=0  (main instance, all scenarios)
//   d1: WIDTH=8,  MSB_FIRST=1
//   d2: WIDTH=12, MSB_FIRST=0
//   d3: WIDTH=16, MSB_FIRST=0
// Expected beat sequences are hand-written nibble lists (first beat in the
// lowest nibble).
// ---------------------------------------------------------------------------
module tb_encoder_scan_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  in_valid_v;
  logic [3:0]  o_ready_v;
  logic [15:0] i_v [4];

  logic [3:0]  in_ready_v, o_valid_v, o_last_v, busy_v, o_zero_v;
  logic [3:0]  o_v [4];

  logic       ir0, ir1, ir2, ir3;
  logic       ov0, ov1, ov2, ov3;
  logic       ol0, ol1, ol2, ol3;
  logic       bz0, bz1, bz2, bz3;
  logic       oz0, oz1, oz2, oz3;
  logic [2:0] oo0, oo1;
  logic [3:0] oo2, oo3;

  encoder_scan_n #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .i(i_v[0][7:0]), .o_valid(ov0), .o_ready(o_ready_v[0]), .o(oo0),
    .o_last(ol0),
`ifdef ENCODER_ZERO_FLAG_EN
    .o_zero(oz0),
`endif
    .busy(bz0)
  );

  encoder_scan_n #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .i(i_v[1][7:0]), .o_valid(ov1), .o_ready(o_ready_v[1]), .o(oo1),
    .o_last(ol1),
`ifdef ENCODER_ZERO_FLAG_EN
    .o_zero(oz1),
`endif
    .busy(bz1)
  );

  encoder_scan_n #(.WIDTH(12), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .i(i_v[2][11:0]), .o_valid(ov2), .o_ready(o_ready_v[2]), .o(oo2),
    .o_last(ol2),
`ifdef ENCODER_ZERO_FLAG_EN
    .o_zero(oz2),
`endif
    .busy(bz2)
  );

  encoder_scan_n #(.WIDTH(16), .MSB_FIRST(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(ir3),
    .i(i_v[3]), .o_valid(ov3), .o_ready(o_ready_v[3]), .o(oo3),
    .o_last(ol3),
`ifdef ENCODER_ZERO_FLAG_EN
    .o_zero(oz3),
`endif
    .busy(bz3)
  );

`ifndef ENCODER_ZERO_FLAG_EN
  assign oz0 = 1'b0;
  assign oz1 = 1'b0;
  assign oz2 = 1'b0;
  assign oz3 = 1'b0;
`endif

  always_comb begin
    in_ready_v = {ir3, ir2, ir1, ir0};
    o_valid_v  = {ov3, ov2, ov1, ov0};
    o_last_v   = {ol3, ol2, ol1, ol0};
    busy_v     = {bz3, bz2, bz1, bz0};
    o_zero_v   = {oz3, oz2, oz1, oz0};
    o_v[0]     = {1'b0, oo0};
    o_v[1]     = {1'b0, oo1};
    o_v[2]     = oo2;
    o_v[3]     = oo3;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Offers vector v to instance d with o_ready high and
  // checks n beats against the nibble list exp, then the IDLE gap cycle.
  task automatic run_vec(input int d, input logic [15:0] v,
                         input logic [63:0] exp, input int n);
    int         guard;
    logic [3:0] e;
    guard = 0;
    o_ready_v[d] = 1'b1;
    while (!in_ready_v[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val($sformatf("d%0d v%0h in_ready wait", d, v), {31'd0, in_ready_v[d]}, 32'd1);
    i_v[d]        = v;
    in_valid_v[d] = 1'b1;
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    i_v[d]        = 16'h5A5A;  // junk: must be ignored while busy
    for (int k = 0; k < n; k++) begin
      e = exp[k*4 +: 4];
      check_val($sformatf("d%0d v%0h b%0d o_valid", d, v, k), {31'd0, o_valid_v[d]}, 32'd1);
      check_val($sformatf("d%0d v%0h b%0d o", d, v, k), {28'd0, o_v[d]}, {28'd0, e});
      check_val($sformatf("d%0d v%0h b%0d o_last", d, v, k), {31'd0, o_last_v[d]},
                (k == n - 1) ? 32'd1 : 32'd0);
      check_val($sformatf("d%0d v%0h b%0d in_ready", d, v, k), {31'd0, in_ready_v[d]}, 32'd0);
`ifdef ENCODER_ZERO_FLAG_EN
      check_val($sformatf("d%0d v%0h b%0d o_zero", d, v, k), {31'd0, o_zero_v[d]}, 32'd0);
`endif
      @(negedge clk);
    end
    check_val($sformatf("d%0d v%0h gap o_valid", d, v), {31'd0, o_valid_v[d]}, 32'd0);
    check_val($sformatf("d%0d v%0h gap in_ready", d, v), {31'd0, in_ready_v[d]}, 32'd1);
    $display("vec d%0d %04h: %0d beats checked", d, v, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid_v = '0;
    o_ready_v  = '1;
    for (int d = 0; d < 4; d++) i_v[d] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    check_val("rst o_valid", {31'd0, o_valid_v[0]}, 32'd0);
    check_val("rst busy", {31'd0, busy_v[0]}, 32'd0);
    check_val("rst o", {28'd0, o_v[0]}, 32'd0);
    check_val("rst o_last", {31'd0, o_last_v[0]}, 32'd0);
    check_val("rst o_zero", {31'd0, o_zero_v[0]}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("post-rst in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    $display("reset: checked");
    @(negedge clk);

    // One-hot sweep
    for (int b = 0; b < 8; b++) begin
      logic [15:0] v;
      logic [63:0] e;
      v = 16'(1) << b;
      e = 64'(b);
      run_vec(0, v, e, 1);
    end

    // Multi-bit, both orders
    run_vec(0, 16'h00A5, 64'h7520, 4);
    run_vec(1, 16'h00A5, 64'h0257, 4);
    run_vec(0, 16'h00FF, 64'h7654_3210, 8);
    run_vec(1, 16'h00FF, 64'h0123_4567, 8);

    // Wide configurations
    run_vec(3, 16'h8001, 64'hF0, 2);
    run_vec(2, 16'h0FFF, 64'hBA98_7654_3210, 12);

    // Backpressure: 0x18, o_ready low for 3 cycles after first beat
    o_ready_v[0]  = 1'b0;
    i_v[0]        = 16'h0018;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("bp c%0d o_valid", c), {31'd0, o_valid_v[0]}, 32'd1);
      check_val($sformatf("bp c%0d o", c), {28'd0, o_v[0]}, 32'd3);
      check_val($sformatf("bp c%0d o_last", c), {31'd0, o_last_v[0]}, 32'd0);
      check_val($sformatf("bp c%0d in_ready", c), {31'd0, in_ready_v[0]}, 32'd0);
      if (c == 3) o_ready_v[0] = 1'b1;
      @(negedge clk);
    end
    check_val("bp last o", {28'd0, o_v[0]}, 32'd4);
    check_val("bp last o_last", {31'd0, o_last_v[0]}, 32'd1);
    check_val("bp last in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    @(negedge clk);
    check_val("bp done o_valid", {31'd0, o_valid_v[0]}, 32'd0);
    $display("backpressure 0018: checked");

    // Zero vector
    i_v[0]        = 16'h0000;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
`ifdef ENCODER_ZERO_FLAG_EN
    check_val("zero o_valid", {31'd0, o_valid_v[0]}, 32'd1);
    check_val("zero o", {28'd0, o_v[0]}, 32'd0);
    check_val("zero o_last", {31'd0, o_last_v[0]}, 32'd1);
    check_val("zero o_zero", {31'd0, o_zero_v[0]}, 32'd1);
    check_val("zero busy", {31'd0, busy_v[0]}, 32'd1);
    @(negedge clk);
    check_val("zero done o_valid", {31'd0, o_valid_v[0]}, 32'd0);
    check_val("zero done in_ready", {31'd0, in_ready_v[0]}, 32'd1);
`else
    for (int c = 0; c < 2; c++) begin
      check_val($sformatf("zero c%0d o_valid", c), {31'd0, o_valid_v[0]}, 32'd0);
      check_val($sformatf("zero c%0d in_ready", c), {31'd0, in_ready_v[0]}, 32'd1);
      check_val($sformatf("zero c%0d busy", c), {31'd0, busy_v[0]}, 32'd0);
      @(negedge clk);
    end
`endif
    $display("zero vector: checked");

    // Reset mid-scan
    i_v[0]        = 16'h00FF;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    check_val("rms b0 o", {28'd0, o_v[0]}, 32'd0);
    @(negedge clk);
    check_val("rms b1 o", {28'd0, o_v[0]}, 32'd1);
    @(negedge clk);
    check_val("rms b2 o", {28'd0, o_v[0]}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rms o_valid", {31'd0, o_valid_v[0]}, 32'd0);
    check_val("rms busy", {31'd0, busy_v[0]}, 32'd0);
    check_val("rms o", {28'd0, o_v[0]}, 32'd0);
    check_val("rms in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rms release in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    $display("reset mid-scan: checked");
    run_vec(0, 16'h0040, 64'h6, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_scan_n.md
# encoder_scan_n

Parametrised, registered bit-scan encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then emits the binary index of every set bit, one index per beat, on a valid/ready output stream. The order is lowest-first or highest-first. It supersedes the fixed 8-to-3 one-hot encoder wherever request vectors can carry more than one set bit, or wherever downstream logic applies backpressure.

## Interface
Parameters:
- WIDTH, 8, request vector width; legal range is WIDTH ≥ 2.
- MSB_FIRST, 0, scan order. 0 = lowest set bit first; 1 = highest set bit first.
- IDX_W, derived localparam equal to $clog2(WIDTH); not overridable.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request vector present on `i`.
- in_ready  output  1  block can accept a vector this cycle.
- i  input  WIDTH  request vector.
- o_valid  output  1  index beat present on `o`.
- o_ready  input  1  downstream accepts the beat.
- o  output  IDX_W  index of the bit currently selected.
- o_last  output  1  current beat is the final one for this vector.
- o_zero  output  1  beat reports an all-zero vector; only present when ENCODER_ZERO_FLAG_EN is defined.
- busy  output  1  scan in progress (state SCAN).

## Operation
- State: a two-state FSM (IDLE, SCAN) plus a WIDTH-bit register `pending`.
- IDLE:
  - `in_ready` = 1 (except during reset).
  - An input is accepted on in_valid && in_ready.
  - If i ≠ 0: `pending` ← i, and the FSM goes to SCAN.
  - If i = 0: handling depends on the Configuration section.
- SCAN:
  - `in_ready` = 0 and `o_valid` = 1.
  - `o` = index of the lowest set bit of `pending`, or the highest set bit when MSB_FIRST = 1.
  - `o_last` = 1 when `pending` has exactly one set bit.
- Beat transfer: a beat transfers on o_valid && o_ready.
  - On transfer, the selected bit of `pending` is cleared.
  - If `o_last` was 1, the FSM returns to IDLE.
- Stability: while o_valid = 1 and o_ready = 0, `o`, `o_last` and `pending` hold unchanged.
- Idle output values: when o_valid = 0, `o` = 0 and `o_last` = 0. The `o_zero` output is 0 whenever o_valid = 0.
- Output logic: `o` and `o_last` are decoded from registered `pending` only. There is no combinational path from `i` or `in_valid` to any output.
- `o_ready` has no effect in IDLE.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State ← IDLE and `pending` ← 0.
  - `o_valid`, `o`, `o_last`, `o_zero` and `busy` are all 0.
  - `in_ready` is forced to 0 while rst_n = 0, and is 1 in the first cycle after release.
- Reset mid-scan: remaining bits are discarded with no further beats, and the next accepted vector starts clean.
- Latency: a vector accepted at edge N gives o_valid = 1 in the cycle following edge N.
- Throughput: with o_ready held at 1, a vector with k set bits occupies k beats plus one IDLE cycle. The next vector is accepted at least k+1 cycles after the previous one.
- Sampling: `in_valid` and `i` are ignored while `in_ready` = 0. The upstream must hold them until the handshake completes.
- Full width: a vector with all WIDTH bits set produces WIDTH beats. `o` walks 0..WIDTH-1, or WIDTH-1..0 when MSB_FIRST = 1.
- Index range: when WIDTH is not a power of two, `o` never exceeds WIDTH-1.

## Configuration
- Macro: ENCODER_ZERO_FLAG_EN.
- Defined:
  - An accepted all-zero vector moves the FSM to SCAN with `pending` = 0.
  - The block emits exactly one beat with o_valid = 1, o = 0, o_last = 1, o_zero = 1.
  - After that beat transfers, the FSM returns to IDLE.
- Not defined:
  - The `o_zero` port is absent.
  - An accepted all-zero vector is consumed silently: the FSM stays in IDLE, `in_ready` stays 1, and no beat is produced.

## Test plan
- One-hot sweep (WIDTH=8, o_ready=1): vectors 0x01, 0x02, …, 0x80 → one beat each, o = 0..7, o_last = 1 on every beat.
- Multi-bit (WIDTH=8): vector 0xA5 with MSB_FIRST=0 → o = 0, 2, 5, 7 on consecutive cycles, o_last = 1 only with o = 7. The same vector with MSB_FIRST=1 → 7, 5, 2, 0.
- Backpressure: vector 0x18 with o_ready low for 3 cycles after the first beat appears → o = 3 held stable for 4 cycles. Then o = 4 with o_last = 1. `in_ready` stays 0 throughout.
- Zero vector:
  - With ENCODER_ZERO_FLAG_EN defined: input 0x00 → one beat with o = 0, o_zero = 1, o_last = 1.
  - Without it: input 0x00 → no beat, and in_ready stays 1.
- Reset mid-scan: 0xFF accepted, rst_n pulled low after the 2nd beat → the next cycle has o_valid = 0, busy = 0, o = 0. After release, vector 0x40 → a single beat with o = 6.
- Wide configuration: WIDTH=16, vector 0x8001 → o = 0 then 15. WIDTH=12, vector 0xFFF → 12 beats, o = 0..11.
